// File: rtl/regfile_multiport_pkg.sv
// Shared defaults, register names and the address-validity rule for the multi-port register file.
package regfile_multiport_pkg;

  localparam int RF_WIDTH    = 16;
  localparam int RF_DEPTH    = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_MAX_READ = 4;

  typedef enum logic [3:0] {
    R0, R1, R2,  R3,  R4,  R5,  R6,  R7,
    R8, R9, R10, R11, R12, R13, R14, R15
  } reg_name_e;

  // An address names a real register unless it is past the end or is a hardwired-zero r0.
  function automatic logic addr_ok(input int addr, input int depth, input logic zero_r0);
    return (addr < depth) && !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, optional write-to-read bypass and the busy view.
module regfile_read_port
  import regfile_multiport_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DEPTH*WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]       busy,
  input  logic                   wr0_vld,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic [WIDTH-1:0]       wr0_dat,
  input  logic                   wr1_vld,
  input  logic [ADDR_W-1:0]      wr1_addr,
  input  logic [WIDTH-1:0]       wr1_dat,
  input  logic                   res_vld,
  input  logic [ADDR_W-1:0]      res_addr,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   rd_busy
);

  logic [WIDTH-1:0] stored_dat;
  logic             stored_busy;
  logic             hit0, hit1, hit_res;

  always_comb begin
    stored_dat  = '0;
    stored_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        stored_dat  = regs[i*WIDTH +: WIDTH];
        stored_busy = busy[i];
      end
    end
  end

  always_comb begin
    hit0    = wr0_vld && (wr0_addr == rd_addr);
    hit1    = wr1_vld && (wr1_addr == rd_addr);
    hit_res = res_vld && (res_addr == rd_addr);
    rd_dat  = '0;
    rd_busy = 1'b0;
    if (rd_en && addr_ok(32'(rd_addr), DEPTH, ZERO_R0 != 0)) begin
      rd_dat  = stored_dat;
      rd_busy = stored_busy;
      if (BYPASS != 0) begin
        if (hit1) begin
          rd_dat = wr1_dat;
        end else if (hit0) begin
          rd_dat = wr0_dat;
        end
        // A pending writeback retires the producer unless a new one claims r this same cycle.
        if ((hit0 || hit1) && !hit_res) begin
          rd_busy = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NUM_READ combinational read ports, two prioritised write ports and a
// per-register busy scoreboard; Reset low clears all state and forces outputs to zero.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       WriteEnable0,
  input  logic [ADDR_W-1:0]          SelectIn0,
  input  logic [WIDTH-1:0]           In0,
  input  logic                       WriteEnable1,
  input  logic [ADDR_W-1:0]          SelectIn1,
  input  logic [WIDTH-1:0]           In1,
  input  logic                       Reserve,
  input  logic [ADDR_W-1:0]          SelectRes,
  input  logic [NUM_READ*ADDR_W-1:0] SelectRd,
  output logic [NUM_READ*WIDTH-1:0]  Out,
  output logic [NUM_READ-1:0]        Busy
);

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [WIDTH-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]       busy_q, busy_d;
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic                   wr0_vld, wr1_vld, res_vld;

  assign wr0_vld = WriteEnable0 && addr_ok(32'(SelectIn0), DEPTH, ZERO_R0 != 0);
  assign wr1_vld = WriteEnable1 && addr_ok(32'(SelectIn1), DEPTH, ZERO_R0 != 0);
  assign res_vld = Reserve && addr_ok(32'(SelectRes), DEPTH, ZERO_R0 != 0);

  // Port 1 is applied after port 0 so it wins a collision; Reserve last so a new producer wins.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr0_vld && (SelectIn0 == ADDR_W'(i))) begin
        regs_d[i] = In0;
        busy_d[i] = 1'b0;
      end
      if (wr1_vld && (SelectIn1 == ADDR_W'(i))) begin
        regs_d[i] = In1;
        busy_d[i] = 1'b0;
      end
      if (res_vld && (SelectRes == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    regfile_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_rd (
      .rd_en   (Reset),
      .rd_addr (SelectRd[k*ADDR_W +: ADDR_W]),
      .regs    (regs_flat),
      .busy    (busy_q),
      .wr0_vld (wr0_vld),
      .wr0_addr(SelectIn0),
      .wr0_dat (In0),
      .wr1_vld (wr1_vld),
      .wr1_addr(SelectIn1),
      .wr1_dat (In1),
      .res_vld (res_vld),
      .res_addr(SelectRes),
      .rd_dat  (Out[k*WIDTH +: WIDTH]),
      .rd_busy (Busy[k])
    );
  end

endmodule
